conv_encoder_punct: RTL and testbench

- Parametrised hardware convolutional encoder, rate 1/N_OUT, with optional tail-bit termination and periodic puncturing.
- Successor to the fixed K=3, rate-1/2 software encoder model used to drive tt_um_viterbi_core.
- Feeds the decoder's symbol input. An erasure mask accompanies each symbol so the downstream depuncturer/branch-metric logic can neutralise punctured positions.
- Bit-exact with the golden encoder convention: LSB state insertion, polynomials applied to {state, in_bit}.

---
 rtl/viterbi_pkg.sv | 51 +++++
 rtl/conv_encoder_punct.sv | 187 ++++++++++++++++++
 tb/tb_conv_encoder_punct.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared convolutional-code helpers: generator extraction, one encoder step, FSM encoding.
`default_nettype none

package viterbi_pkg;

  // Widest supported code: K=9 (8 state bits), four generators.
  localparam int K_MAX = 9;
  localparam int M_MAX = K_MAX - 1;
  localparam int N_MAX = 4;
  localparam int G_W   = K_MAX * N_MAX;
  localparam int STEP_W = M_MAX + N_MAX;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t S_DATA = 1'b0;
  localparam fsm_state_t S_TAIL = 1'b1;

  function automatic logic [K_MAX-1:0] get_poly(input logic [G_W-1:0] g_oct,
                                                input int k,
                                                input int n_out,
                                                input int i);
    logic [G_W-1:0] shifted;
    shifted = g_oct >> ((n_out - 1 - i) * k);
    return K_MAX'(shifted) & K_MAX'((1 << k) - 1);
  endfunction

  // Returns {next_state, sym} right-aligned: sym occupies the low n_out bits
  // with y0 at bit n_out-1, next_state sits directly above it.
  function automatic logic [STEP_W-1:0] enc_step(input logic [M_MAX-1:0] state,
                                                 input logic b,
                                                 input int k,
                                                 input int n_out,
                                                 input logic [G_W-1:0] g_oct);
    logic [K_MAX-1:0]  sr;
    logic [N_MAX-1:0]  sym;
    logic [M_MAX-1:0]  next_state;
    logic [STEP_W-1:0] packed_out;
    sr  = {state, b} & K_MAX'((1 << k) - 1);
    sym = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < n_out) begin
        sym = {sym[N_MAX-2:0], ^(sr & get_poly(g_oct, k, n_out, i))};
      end
    end
    next_state = {state[M_MAX-2:0], b} & M_MAX'((1 << (k - 1)) - 1);
    packed_out = (STEP_W'(next_state) << n_out) | STEP_W'(sym);
    return packed_out;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_encoder_punct.sv
// +------------------------------------------------------------------------+
// | conv_encoder_punct: rate 1/N_OUT convolutional encoder, tail + puncture |
// | Revision: 1.1                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module conv_encoder_punct
    import viterbi_pkg::*;
#(
    parameter int                            K            = 3,
    parameter int                            N_OUT        = 2,
    parameter logic [N_OUT*K-1:0]            G_OCT        = {3'o7, 3'o5},
    parameter bit                            TAIL_EN      = 1'b1,
    parameter int                            PUNCT_PERIOD = 1,
    parameter logic [PUNCT_PERIOD*N_OUT-1:0] PUNCT_MASK   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_OUT-1:0] out_sym,
    output logic [N_OUT-1:0] out_mask,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int M  = K - 1;
    localparam int PW = (PUNCT_PERIOD > 1) ? $clog2(PUNCT_PERIOD) : 1;
    localparam int TW = $clog2(K);

    if (K < 3 || K > K_MAX) begin : g_bad_k
        $error("conv_encoder_punct: K out of range 3..9");
    end
    if (N_OUT < 2 || N_OUT > N_MAX) begin : g_bad_n
        $error("conv_encoder_punct: N_OUT out of range 2..4");
    end
    if (PUNCT_PERIOD < 1 || PUNCT_PERIOD > 8) begin : g_bad_period
        $error("conv_encoder_punct: PUNCT_PERIOD out of range 1..8");
    end
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chk_poly
        if (G_OCT[(N_OUT-1-gi)*K + K-1] == 1'b0) begin : g_bad_poly
            $error("conv_encoder_punct: generator without tap on bit K-1");
        end
    end
    for (genvar gp = 0; gp < PUNCT_PERIOD; gp++) begin : g_chk_mask
        if (PUNCT_MASK[gp*N_OUT +: N_OUT] == '0) begin : g_bad_col
            $error("conv_encoder_punct: all-zero puncture column");
        end
    end

    fsm_state_t         r_state, w_state_nxt;
    logic [M-1:0]       r_enc_state, w_enc_state_nxt;
    logic [PW-1:0]      r_phase, w_phase_nxt;
    logic [TW-1:0]      r_tail_cnt, w_tail_cnt_nxt;
    logic [N_OUT-1:0]   r_out_sym, w_out_sym_nxt;
    logic [N_OUT-1:0]   r_out_mask, w_out_mask_nxt;
    logic               r_out_last, w_out_last_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_slot_free;
    logic               w_accept;
    logic               w_enc_bit;
    logic [N_OUT-1:0]   w_punct_col;
    logic [M+N_OUT-1:0] w_step;
    logic [M-1:0]       w_next_state;
    logic [N_OUT-1:0]   w_sym;
    logic [PW-1:0]      w_phase_inc;
    logic               w_frame_done;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state == S_DATA) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_enc_bit   = (r_state == S_DATA) ? in_bit : 1'b0;

    assign w_step = (M+N_OUT)'(enc_step(M_MAX'(r_enc_state), w_enc_bit, K, N_OUT, G_W'(G_OCT)));
    assign {w_next_state, w_sym} = w_step;

    assign w_phase_inc  = (r_phase == PW'(PUNCT_PERIOD - 1)) ? '0 : r_phase + 1'b1;
    assign w_frame_done = r_out_valid && out_ready && r_out_last;

    always_comb begin
        w_punct_col = PUNCT_MASK[N_OUT-1:0];
        for (int p = 0; p < PUNCT_PERIOD; p++) begin
            if (r_phase == PW'(p)) begin
                w_punct_col = PUNCT_MASK[p*N_OUT +: N_OUT];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_enc_state_nxt = r_enc_state;
        w_phase_nxt     = r_phase;
        w_tail_cnt_nxt  = r_tail_cnt;
        w_out_sym_nxt   = r_out_sym;
        w_out_mask_nxt  = r_out_mask;
        w_out_last_nxt  = r_out_last;
        w_out_valid_nxt = r_out_valid;
        w_busy_nxt      = r_busy;

        if (out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
        if (w_frame_done) begin
            w_busy_nxt = 1'b0;
        end

        if (r_state == S_DATA) begin
            if (w_accept) begin
                w_out_sym_nxt   = w_sym & w_punct_col;
                w_out_mask_nxt  = w_punct_col;
                w_out_last_nxt  = 1'b0;
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
                w_enc_state_nxt = w_next_state;
                w_phase_nxt     = w_phase_inc;
                if (in_last) begin
                    if (TAIL_EN) begin
                        w_state_nxt    = S_TAIL;
                        w_tail_cnt_nxt = '0;
                    end else begin
                        w_out_last_nxt  = 1'b1;
                        w_enc_state_nxt = '0;
                        w_phase_nxt     = '0;
                    end
                end
            end
        end else begin
            // Tail symbols are never punctured and do not advance the phase.
            if (w_slot_free) begin
                w_out_sym_nxt   = w_sym;
                w_out_mask_nxt  = '1;
                w_out_last_nxt  = 1'b0;
                w_out_valid_nxt = 1'b1;
                w_enc_state_nxt = w_next_state;
                w_tail_cnt_nxt  = r_tail_cnt + 1'b1;
                if (r_tail_cnt == TW'(M - 1)) begin
                    w_out_last_nxt  = 1'b1;
                    w_enc_state_nxt = '0;
                    w_phase_nxt     = '0;
                    w_tail_cnt_nxt  = '0;
                    w_state_nxt     = S_DATA;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_DATA;
            r_enc_state <= '0;
            r_phase     <= '0;
            r_tail_cnt  <= '0;
            r_out_sym   <= '0;
            r_out_mask  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_enc_state <= w_enc_state_nxt;
            r_phase     <= w_phase_nxt;
            r_tail_cnt  <= w_tail_cnt_nxt;
            r_out_sym   <= w_out_sym_nxt;
            r_out_mask  <= w_out_mask_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign out_sym    = r_out_sym;
    assign out_mask   = r_out_mask;
    assign out_last   = r_out_last;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign frame_done = w_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: three configurations checked against hand-computed symbol tables.
`default_nettype none

module tb_conv_encoder_punct;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: K=3 rate 1/2 with tail; 1: punctured, no tail; 2: rate 1/3 with tail.
  logic in_valid_s[3], in_bit_s[3], in_last_s[3], out_ready_s[3];
  logic ir_s[3], ov_s[3], ol_s[3], bz_s[3], fd_s[3];
  logic [1:0] sym_a, mask_a, sym_p, mask_p;
  logic [2:0] sym_r, mask_r;
  logic [3:0] obs_sym[3], obs_mask[3];

  always_comb begin
    obs_sym[0]  = {2'b00, sym_a};
    obs_sym[1]  = {2'b00, sym_p};
    obs_sym[2]  = {1'b0, sym_r};
    obs_mask[0] = {2'b00, mask_a};
    obs_mask[1] = {2'b00, mask_p};
    obs_mask[2] = {1'b0, mask_r};
  end

  conv_encoder_punct u_a (
    .clk(clk), .rst_n(rst_n),
    .in_bit(in_bit_s[0]), .in_last(in_last_s[0]), .in_valid(in_valid_s[0]), .in_ready(ir_s[0]),
    .out_sym(sym_a), .out_mask(mask_a), .out_last(ol_s[0]), .out_valid(ov_s[0]),
    .out_ready(out_ready_s[0]), .busy(bz_s[0]), .frame_done(fd_s[0])
  );

  conv_encoder_punct #(.PUNCT_PERIOD(2), .PUNCT_MASK(4'b1011), .TAIL_EN(1'b0)) u_p (
    .clk(clk), .rst_n(rst_n),
    .in_bit(in_bit_s[1]), .in_last(in_last_s[1]), .in_valid(in_valid_s[1]), .in_ready(ir_s[1]),
    .out_sym(sym_p), .out_mask(mask_p), .out_last(ol_s[1]), .out_valid(ov_s[1]),
    .out_ready(out_ready_s[1]), .busy(bz_s[1]), .frame_done(fd_s[1])
  );

  conv_encoder_punct #(.N_OUT(3), .G_OCT(9'o753)) u_r (
    .clk(clk), .rst_n(rst_n),
    .in_bit(in_bit_s[2]), .in_last(in_last_s[2]), .in_valid(in_valid_s[2]), .in_ready(ir_s[2]),
    .out_sym(sym_r), .out_mask(mask_r), .out_last(ol_s[2]), .out_valid(ov_s[2]),
    .out_ready(out_ready_s[2]), .busy(bz_s[2]), .frame_done(fd_s[2])
  );

  typedef struct {
    logic b;
    logic last;
  } in_t;

  typedef struct {
    logic [3:0] sym;
    logic [3:0] mask;
    logic       last;
  } exp_t;

  in_t  in_tab[16];
  exp_t exp_tab[24];
  int   n_in;
  int   n_exp;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_tabs();
    n_in  = 0;
    n_exp = 0;
  endtask

  task automatic add_in(input logic b, input logic last);
    in_tab[n_in].b    = b;
    in_tab[n_in].last = last;
    n_in++;
  endtask

  task automatic add_exp(input logic [3:0] sym, input logic [3:0] mask, input logic last);
    exp_tab[n_exp].sym  = sym;
    exp_tab[n_exp].mask = mask;
    exp_tab[n_exp].last = last;
    n_exp++;
  endtask

  // Streams in_tab into DUT `sel` and compares every output handshake against exp_tab.
  task automatic run(input int sel, input bit stall, input bit bubble_chk);
    int ii = 0;
    int ei = 0;
    int cyc = 0;
    int bubbles = 0;
    int frames = 0;
    int fd_cnt = 0;
    bit started = 1'b0;
    bit held_v = 1'b0;
    logic [3:0] hs, hm;
    logic hl;
    logic rdy;
    hs = '0;
    hm = '0;
    hl = 1'b0;
    for (int e = 0; e < n_exp; e++) begin
      if (exp_tab[e].last) frames++;
    end
    while (ei < n_exp && cyc < 300) begin
      @(negedge clk);
      rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready_s[sel] = rdy;
      if (ii < n_in) begin
        in_valid_s[sel] = 1'b1;
        in_bit_s[sel]   = in_tab[ii].b;
        in_last_s[sel]  = in_tab[ii].last;
      end else begin
        in_valid_s[sel] = 1'b0;
        in_bit_s[sel]   = 1'b0;
        in_last_s[sel]  = 1'b0;
      end
      #1;
      if (held_v) begin
        chk("stall_sym_stable", obs_sym[sel], hs);
        chk("stall_mask_stable", obs_mask[sel], hm);
        chk("stall_last_stable", ol_s[sel], hl);
      end
      held_v = 1'b0;
      if (ov_s[sel] && !rdy) begin
        chk("in_ready_stall", ir_s[sel], 1'b0);
        hs = obs_sym[sel];
        hm = obs_mask[sel];
        hl = ol_s[sel];
        held_v = 1'b1;
      end
      if (ov_s[sel]) started = 1'b1;
      else if (started) bubbles++;
      if (ov_s[sel] && rdy) begin
        chk($sformatf("sym[%0d]", ei), obs_sym[sel], exp_tab[ei].sym);
        chk($sformatf("mask[%0d]", ei), obs_mask[sel], exp_tab[ei].mask);
        chk($sformatf("last[%0d]", ei), ol_s[sel], exp_tab[ei].last);
        ei++;
      end
      if (fd_s[sel]) fd_cnt++;
      if (in_valid_s[sel] && ir_s[sel]) ii++;
      cyc++;
    end
    chk("symbols_seen", ei, n_exp);
    @(negedge clk);
    out_ready_s[sel] = 1'b1;
    in_valid_s[sel]  = 1'b0;
    in_last_s[sel]   = 1'b0;
    #1;
    chk("idle_out_valid", ov_s[sel], 1'b0);
    chk("idle_busy", bz_s[sel], 1'b0);
    chk("frame_done_pulses", fd_cnt, frames);
    if (bubble_chk) chk("bubbles", bubbles, 0);
  endtask

  task automatic load_basic_frame();
    logic [7:0] bits;
    logic [1:0] syms[10];
    bits = 8'b1010_1010;
    syms = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
    clear_tabs();
    for (int i = 0; i < 8; i++) add_in(bits[i], i == 7);
    for (int i = 0; i < 10; i++) add_exp({2'b00, syms[i]}, 4'b0011, i == 9);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      in_valid_s[s]  = 1'b0;
      in_bit_s[s]    = 1'b0;
      in_last_s[s]   = 1'b0;
      out_ready_s[s] = 1'b1;
    end
    #2;
    chk("rst_out_valid", ov_s[0], 1'b0);
    chk("rst_out_sym", obs_sym[0], 4'h0);
    chk("rst_out_mask", obs_mask[0], 4'h0);
    chk("rst_out_last", ol_s[0], 1'b0);
    chk("rst_busy", bz_s[0], 1'b0);
    chk("rst_frame_done", fd_s[0], 1'b0);
    chk("rst_p_out_valid", ov_s[1], 1'b0);
    chk("rst_r_out_valid", ov_s[2], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", ir_s[0], 1'b1);

    // Basic frame, free-flowing output.
    load_basic_frame();
    run(0, 1'b0, 1'b1);

    // Same frame under a 1,0,0,1 out_ready pattern.
    load_basic_frame();
    run(0, 1'b1, 1'b0);

    // Punctured, no tail; the 3-bit middle frame leaves phase at 1 unless reset by out_last.
    clear_tabs();
    add_in(0, 0); add_in(1, 0); add_in(0, 0); add_in(1, 1);
    add_in(0, 0); add_in(1, 0); add_in(0, 1);
    add_in(1, 0); add_in(0, 1);
    add_exp(4'b0000, 4'b0011, 0); add_exp(4'b0010, 4'b0010, 0);
    add_exp(4'b0010, 4'b0011, 0); add_exp(4'b0000, 4'b0010, 1);
    add_exp(4'b0000, 4'b0011, 0); add_exp(4'b0010, 4'b0010, 0);
    add_exp(4'b0010, 4'b0011, 1);
    add_exp(4'b0011, 4'b0011, 0); add_exp(4'b0010, 4'b0010, 1);
    run(1, 1'b0, 1'b0);

    // Rate 1/3, single bit frame.
    clear_tabs();
    add_in(1, 1);
    add_exp(4'b0111, 4'b0111, 0);
    add_exp(4'b0101, 4'b0111, 0);
    add_exp(4'b0110, 4'b0111, 1);
    run(2, 1'b0, 1'b0);

    // Back-to-back: frame B's first bit waits through A's tail and enters with no bubble.
    clear_tabs();
    add_in(1, 0); add_in(1, 1); add_in(1, 1);
    add_exp(4'b0011, 4'b0011, 0); add_exp(4'b0001, 4'b0011, 0);
    add_exp(4'b0001, 4'b0011, 0); add_exp(4'b0011, 4'b0011, 1);
    add_exp(4'b0011, 4'b0011, 0); add_exp(4'b0010, 4'b0011, 0);
    add_exp(4'b0011, 4'b0011, 1);
    run(0, 1'b0, 1'b1);

    // Reset mid-frame after 3 of 8 bits.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid_s[0] = 1'b1;
      in_bit_s[0]   = i[0];
      in_last_s[0]  = 1'b0;
    end
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    #1;
    chk("midframe_busy", bz_s[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", ov_s[0], 1'b0);
    chk("async_rst_busy", bz_s[0], 1'b0);
    chk("async_rst_out_last", ol_s[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_tabs();
    add_in(1, 1);
    add_exp(4'b0011, 4'b0011, 0);
    add_exp(4'b0010, 4'b0011, 0);
    add_exp(4'b0011, 4'b0011, 1);
    run(0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
